// File: rtl/sp_slew.sv
// Setpoint slew limiter: registered pitch/roll/yaw/thrust outputs move toward their targets
// by at most STEP per update tick. Define SP_YAW_SLEW_EN to slew yaw as well; otherwise yaw is a plain register.
module sp_slew #(
  parameter int STEP    = 16,
  parameter int UPD_DIV = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [15:0] d_ptch_in,
  input  logic signed [15:0] d_roll_in,
  input  logic signed [15:0] d_yaw_in,
  input  logic        [8:0]  thrst_in,
  input  logic               motors_off,
  output logic signed [15:0] d_ptch_out,
  output logic signed [15:0] d_roll_out,
  output logic signed [15:0] d_yaw_out,
  output logic        [8:0]  thrst_out,
  output logic               settled
);

  localparam int                 CW      = $clog2(UPD_DIV);
  localparam logic [CW-1:0]      CNT_MAX = CW'(UPD_DIV - 1);
  localparam logic signed [16:0] STEP_S  = 17'(STEP);

  logic [CW-1:0] cnt;
  logic          tick;

  assign tick = (cnt == CNT_MAX);

  // The sum always lies between cur and tgt, so truncating back to 16 bits cannot wrap.
  function automatic logic signed [15:0] slew(input logic signed [15:0] cur,
                                              input logic signed [15:0] tgt);
    logic signed [16:0] diff;
    logic signed [16:0] adj;
    diff = {tgt[15], tgt} - {cur[15], cur};
    if (diff > STEP_S)
      adj = STEP_S;
    else if (diff < -STEP_S)
      adj = -STEP_S;
    else
      adj = diff;
    return cur + 16'(adj);
  endfunction

  // Thrust is zero-extended into the signed path; its result stays within 0..511.
  logic signed [15:0] thrst_next;
  assign thrst_next = slew({7'b0, thrst_out}, {7'b0, thrst_in});

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      d_ptch_out <= '0;
      d_roll_out <= '0;
      d_yaw_out  <= '0;
      thrst_out  <= '0;
      settled    <= 1'b0;
    end else begin
      settled <= (d_ptch_out == d_ptch_in) && (d_roll_out == d_roll_in) &&
                 (d_yaw_out == d_yaw_in) && (thrst_out == thrst_in);
      if (motors_off) begin
        cnt        <= '0;
        d_ptch_out <= '0;
        d_roll_out <= '0;
        d_yaw_out  <= '0;
        thrst_out  <= '0;
      end else begin
        cnt <= tick ? '0 : cnt + 1'b1;
        if (tick) begin
          d_ptch_out <= slew(d_ptch_out, d_ptch_in);
          d_roll_out <= slew(d_roll_out, d_roll_in);
          thrst_out  <= 9'(thrst_next);
`ifdef SP_YAW_SLEW_EN
          d_yaw_out  <= slew(d_yaw_out, d_yaw_in);
`endif
        end
`ifndef SP_YAW_SLEW_EN
        d_yaw_out <= d_yaw_in;
`endif
      end
    end
  end

endmodule

// File: tb/tb_sp_slew.sv
// Bench for sp_slew: two instances (STEP 16 and 20000, UPD_DIV 4) checked every cycle against
// an arithmetic model, plus hand-computed ramp values.
module tb_sp_slew;

  localparam int UPD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [15:0] ptch_in = '0, roll_in = '0, yaw_in = '0;
  logic        [8:0]  thr_in = '0;
  logic               moff = 1'b0;

  logic signed [15:0] p0, r0, y0, p1, r1, y1;
  logic        [8:0]  t0, t1;
  logic               s0, s1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sp_slew #(.STEP(16), .UPD_DIV(UPD)) dut0 (
    .clk(clk), .rst(rst), .d_ptch_in(ptch_in), .d_roll_in(roll_in), .d_yaw_in(yaw_in),
    .thrst_in(thr_in), .motors_off(moff), .d_ptch_out(p0), .d_roll_out(r0),
    .d_yaw_out(y0), .thrst_out(t0), .settled(s0));

  sp_slew #(.STEP(20000), .UPD_DIV(UPD)) dut1 (
    .clk(clk), .rst(rst), .d_ptch_in(ptch_in), .d_roll_in(roll_in), .d_yaw_in(yaw_in),
    .thrst_in(thr_in), .motors_off(moff), .d_ptch_out(p1), .d_roll_out(r1),
    .d_yaw_out(y1), .thrst_out(t1), .settled(s1));

  // Reference model: outputs as plain integers, index 0..3 = pitch, roll, yaw, thrust.
  int stp [2] = '{16, 20000};
  int mo  [2][4];
  int mc  [2];
  int ms  [2];

  function automatic int approach(int cur, int tgt, int step);
    int d;
    d = tgt - cur;
    if (d > step) d = step;
    if (d < -step) d = -step;
    return cur + d;
  endfunction

  initial begin
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 4; k++) mo[i][k] = 0;
      mc[i] = 0;
      ms[i] = 0;
    end
  end

  always @(posedge clk) begin
    int tg [4];
    tg[0] = int'(ptch_in);
    tg[1] = int'(roll_in);
    tg[2] = int'(yaw_in);
    tg[3] = int'(thr_in);
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        for (int k = 0; k < 4; k++) mo[i][k] = 0;
        mc[i] = 0;
        ms[i] = 0;
      end else begin
        ms[i] = (mo[i][0] == tg[0] && mo[i][1] == tg[1] &&
                 mo[i][2] == tg[2] && mo[i][3] == tg[3]) ? 1 : 0;
        if (moff) begin
          for (int k = 0; k < 4; k++) mo[i][k] = 0;
          mc[i] = 0;
        end else begin
          if (mc[i] == UPD - 1) begin
            mc[i] = 0;
            mo[i][0] = approach(mo[i][0], tg[0], stp[i]);
            mo[i][1] = approach(mo[i][1], tg[1], stp[i]);
            mo[i][3] = approach(mo[i][3], tg[3], stp[i]);
`ifdef SP_YAW_SLEW_EN
            mo[i][2] = approach(mo[i][2], tg[2], stp[i]);
`endif
          end else begin
            mc[i] = mc[i] + 1;
          end
`ifndef SP_YAW_SLEW_EN
          mo[i][2] = tg[2];
`endif
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("m0_ptch", int'(p0), mo[0][0]);
    chk("m0_roll", int'(r0), mo[0][1]);
    chk("m0_yaw",  int'(y0), mo[0][2]);
    chk("m0_thr",  int'(t0), mo[0][3]);
    chk("m0_set",  int'(s0), ms[0]);
    chk("m1_ptch", int'(p1), mo[1][0]);
    chk("m1_roll", int'(r1), mo[1][1]);
    chk("m1_yaw",  int'(y1), mo[1][2]);
    chk("m1_thr",  int'(t1), mo[1][3]);
    chk("m1_set",  int'(s1), ms[1]);
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  int exp_p0 [7] = '{16, 32, 48, 64, 80, 96, 100};
  int exp_r0 [7] = '{-16, -32, -40, -40, -40, -40, -40};
  int exp_p1 [4] = '{12767, -7233, -27233, -32768};
  int sel;

  initial begin
    run(3);
    chk("rst_ptch", int'(p0), 0);
    chk("rst_set", int'(s0), 0);

    rst = 1'b0;
    ptch_in = 16'sd100;
    roll_in = -16'sd40;
    for (int i = 0; i < 7; i++) begin
      run(UPD);
      chk("ramp_ptch", int'(p0), exp_p0[i]);
      chk("ramp_roll", int'(r0), exp_r0[i]);
    end
    run(1);
    chk("settled_hi", int'(s0), 1);

    roll_in = 16'sd5;
    run(2);
    roll_in = -16'sd40;
    run(1);
    chk("hold_roll", int'(r0), -40);

    ptch_in = 16'sd32767;
    moff = 1'b1;
    run(1);
    chk("moff_p0", int'(p0), 0);
    chk("moff_p1", int'(p1), 0);
    moff = 1'b0;
    run(UPD - 1);
    chk("moff_wait", int'(p1), 0);
    run(1);
    chk("moff_first", int'(p1), 20000);
    chk("moff_first0", int'(p0), 16);
    run(UPD);
    chk("big_top", int'(p1), 32767);
    ptch_in = -16'sd32768;
    for (int i = 0; i < 4; i++) begin
      run(UPD);
      chk("big_down", int'(p1), exp_p1[i]);
    end

    moff = 1'b1;
    run(1);
    moff = 1'b0;
    thr_in = 9'd511;
    run(31 * UPD);
    chk("thr_31", int'(t0), 496);
    run(UPD);
    chk("thr_32", int'(t0), 511);

    run(UPD - 1);
    rst = 1'b1;
    run(1);
    chk("rst_mid_p", int'(p0), 0);
    chk("rst_mid_t", int'(t0), 0);
    chk("rst_mid_s", int'(s0), 0);
    rst = 1'b0;
    yaw_in = -16'sd500;
    run(1);
`ifndef SP_YAW_SLEW_EN
    chk("yaw_copy", int'(y0), -500);
`endif

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) < 6) begin
        sel = $urandom_range(0, 5);
        case (sel)
          0: ptch_in = 16'sd0;
          1: ptch_in = 16'sd32767;
          2: ptch_in = -16'sd32768;
          default: ptch_in = 16'($urandom);
        endcase
      end
      if ($urandom_range(0, 99) < 6) roll_in = 16'($urandom_range(0, 200)) - 16'sd100;
      if ($urandom_range(0, 99) < 4) yaw_in  = 16'($urandom);
      if ($urandom_range(0, 99) < 5) thr_in  = 9'($urandom);
      moff = ($urandom_range(0, 99) < 2);
      rst  = ($urandom_range(0, 999) < 3);
      run(1);
    end
    rst = 1'b0;
    moff = 1'b0;
    run(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
